// File: rtl/maxnet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_pkg
// Description : Shared constants and state type for the 4-neuron MaxNet
//               sequencer. Provides the neuron count, IEEE-754 single
//               constants used for the weight rows and the FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package maxnet_pkg;

    localparam int N = 4;

    localparam logic [31:0] FP_ONE     = 32'h3F800000;  // +1.0
    localparam logic [31:0] FP_NEG_EPS = 32'hBE000000;  // -0.125
    localparam logic [31:0] FP_ZERO    = 32'h00000000;  // +0.0

    // Explicit 3-bit state encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_MULT   = 3'd2;
    localparam logic [2:0] ST_SUM    = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD   = ST_LOAD,
        MULT   = ST_MULT,
        SUM    = ST_SUM,
        UPDATE = ST_UPDATE,
        DONE   = ST_DONE
    } state_t;

    // ReLU on a single-precision bit pattern: any value with the sign bit set
    // (including -0.0) collapses to +0.0.
    function automatic logic [31:0] relu_fp(input logic [31:0] v);
        return v[31] ? FP_ZERO : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/survivor_encoder.sv
`default_nettype none
// ============================================================================
// Module      : survivor_encoder
// Description : Combinational summary of the ProcessUnit "still alive" flags.
//               Ports: pu_s[3:0] in  - nonzero flags from the ProcessUnits
//                      cnt[2:0]  out - number of flags set
//                      first_idx out - index of the lowest set flag (0 if none)
// Revision    : 1.0 - initial release
// ============================================================================
module survivor_encoder
    import maxnet_pkg::*;
(
    input  logic [3:0] pu_s,
    output logic [2:0] cnt,
    output logic [1:0] first_idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        cnt       = 3'd0;
        first_idx = 2'd0;
        for (int i = N - 1; i >= 0; i--) begin
            cnt = cnt + {2'b00, pu_s[i]};
            if (pu_s[i]) begin
                first_idx = 2'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/maxnet_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_sequencer
// Description : Iteration controller and activation buffer for a 4-neuron
//               MaxNet built from an external ProcessUnit array.
//               Ports: clock, reset (sync, active-high), start
//                      x_in[3:0]      - input vector, captured and rectified
//                      pu_out/pu_s    - ProcessUnit results, sampled in UPDATE
//                      pu_x/pu_w      - activation broadcast and weight rows
//                      load_mult/load_sum - ProcessUnit strobes
//                      busy, done, winner, max_value, no_winner, timeout,
//                      iter_count     - status and result
// Revision    : 1.0 - initial release
// ============================================================================
module maxnet_sequencer
    import maxnet_pkg::*;
#(
    parameter int          MAX_ITER = 255,
    parameter logic [31:0] W_SELF   = FP_ONE,
    parameter logic [31:0] W_INHIB  = FP_NEG_EPS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0][31:0]      x_in,
    input  logic [3:0][31:0]      pu_out,
    input  logic [3:0]            pu_s,
    output logic [3:0][31:0]      pu_x,
    output logic [3:0][3:0][31:0] pu_w,
    output logic                  load_mult,
    output logic                  load_sum,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            winner,
    output logic [31:0]           max_value,
    output logic                  no_winner,
    output logic                  timeout,
    output logic [7:0]            iter_count
);

    state_t           r_state;
    state_t           w_next;
    logic [3:0][31:0] r_act;
    logic             r_load_mult;
    logic             r_load_sum;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_winner;
    logic [31:0]      r_max_value;
    logic             r_no_winner;
    logic             r_timeout;
    logic [7:0]       r_iter_count;

    logic [2:0]       w_cnt;
    logic [1:0]       w_first;
    logic             w_last_iter;

    survivor_encoder u_survivor_encoder (
        .pu_s      (pu_s),
        .cnt       (w_cnt),
        .first_idx (w_first)
    );

    // Constant weight rows: diagonal self-excitation, lateral inhibition.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign pu_w[gi][gj] = (gi == gj) ? W_SELF : W_INHIB;
        end
    end

    // The iteration finishing in this UPDATE would be number MAX_ITER.
    assign w_last_iter = ({1'b0, r_iter_count} + 9'd1) == 9'(MAX_ITER);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = MULT;
            MULT:    w_next = SUM;
            SUM:     w_next = UPDATE;
            UPDATE:  w_next = ((w_cnt <= 3'd1) || w_last_iter) ? DONE : MULT;
            DONE:    if (start) w_next = LOAD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_act        <= '0;
            r_load_mult  <= 1'b0;
            r_load_sum   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_winner     <= 2'd0;
            r_max_value  <= FP_ZERO;
            r_no_winner  <= 1'b0;
            r_timeout    <= 1'b0;
            r_iter_count <= 8'd0;
        end else begin
            r_state <= w_next;
            // Status/strobes are decoded from the next state so they are
            // registered yet line up exactly with the state they describe.
            r_load_mult <= (w_next == MULT);
            r_load_sum  <= (w_next == SUM);
            r_busy      <= (w_next inside {LOAD, MULT, SUM, UPDATE});
            r_done      <= (w_next == DONE);

            case (r_state)
                LOAD: begin
                    for (int i = 0; i < N; i++) begin
                        r_act[i] <= relu_fp(x_in[i]);
                    end
                    r_iter_count <= 8'd0;
                    r_winner     <= 2'd0;
                    r_max_value  <= FP_ZERO;
                    r_no_winner  <= 1'b0;
                    r_timeout    <= 1'b0;
                end
                UPDATE: begin
                    r_act        <= pu_out;
                    r_iter_count <= r_iter_count + 8'd1;
                    if (w_cnt == 3'd0) begin
                        r_no_winner <= 1'b1;
                        r_winner    <= 2'd0;
                        r_max_value <= FP_ZERO;
                    end else if ((w_cnt == 3'd1) || w_last_iter) begin
                        // With one survivor first_idx is that survivor; on
                        // timeout the lowest surviving index is reported.
                        r_winner    <= w_first;
                        r_max_value <= pu_out[w_first];
                        r_timeout   <= (w_cnt != 3'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pu_x       = r_act;
    assign load_mult  = r_load_mult;
    assign load_sum   = r_load_sum;
    assign busy       = r_busy;
    assign done       = r_done;
    assign winner     = r_winner;
    assign max_value  = r_max_value;
    assign no_winner  = r_no_winner;
    assign timeout    = r_timeout;
    assign iter_count = r_iter_count;

endmodule
`default_nettype wire

// File: tb/tb_maxnet_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxnet_sequencer
// Description : Self-checking bench for maxnet_sequencer with a behavioural
//               ProcessUnit array, an iteration-level reference model and a
//               scoreboard monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxnet_sequencer;

    localparam int          MAX_ITER = 8;
    localparam logic [31:0] C_W_SELF  = 32'h3F800000;
    localparam logic [31:0] C_W_INHIB = 32'hBE000000;

    typedef logic [3:0][31:0] vec_t;
    typedef struct {
        logic [1:0]  winner;
        logic [31:0] max_value;
        logic        no_winner;
        logic        timeout;
        logic [7:0]  iters;
        int unsigned done_cyc;
    } res_t;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  start;
    vec_t                  x_in;
    vec_t                  pu_out;
    logic [3:0]            pu_s;
    vec_t                  pu_x;
    logic [3:0][3:0][31:0] pu_w;
    logic                  load_mult, load_sum, busy, done;
    logic [1:0]            winner;
    logic [31:0]           max_value;
    logic                  no_winner, timeout;
    logic [7:0]            iter_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    res_t res_q[$];
    vec_t act_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    maxnet_sequencer #(.MAX_ITER(MAX_ITER)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .x_in       (x_in),
        .pu_out     (pu_out),
        .pu_s       (pu_s),
        .pu_x       (pu_x),
        .pu_w       (pu_w),
        .load_mult  (load_mult),
        .load_sum   (load_sum),
        .busy       (busy),
        .done       (done),
        .winner     (winner),
        .max_value  (max_value),
        .no_winner  (no_winner),
        .timeout    (timeout),
        .iter_count (iter_count)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- single-precision helpers (normals only) -------------
    function automatic real sp2r(input logic [31:0] b);
        if (b[30:23] == 8'd0) return 0.0;
        return $bitstoreal({b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0});
    endfunction

    // Truncating conversion with ReLU: non-positive results give +0.0.
    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int          e;
        if (r <= 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e < 1) return 32'h0;
        if (e > 254) return 32'h7F7FFFFF;
        return {1'b0, 8'(e), d[51:29]};
    endfunction

    // One neuron: relu(x_i - eps * sum_{j!=i} x_j)
    function automatic logic [31:0] neuron(input int i, input vec_t x);
        real acc = 0.0;
        for (int j = 0; j < 4; j++) begin
            acc += ((i == j) ? 1.0 : -0.125) * sp2r(x[j]);
        end
        return r2sp(acc);
    endfunction

    function automatic vec_t layer(input vec_t x);
        vec_t y;
        for (int i = 0; i < 4; i++) y[i] = neuron(i, x);
        return y;
    endfunction

    function automatic logic [3:0] nz(input vec_t y);
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = (y[i] != 32'h0);
        return s;
    endfunction

    // ---------------- behavioural ProcessUnit array -----------------------
    vec_t pu_latch;
    always @(posedge clock) begin
        if (load_mult) pu_latch <= pu_x;
        if (load_sum) begin
            pu_out <= layer(pu_latch);
            pu_s   <= nz(layer(pu_latch));
        end
    end

    // ---------------- reference model: whole run at once ------------------
    task automatic model_run(input vec_t x, output res_t r);
        vec_t a;
        int   n, cnt, first;
        for (int i = 0; i < 4; i++) a[i] = x[i][31] ? 32'h0 : x[i];
        n = 0;
        do begin
            a = layer(a);
            n++;
            act_q.push_back(a);
            cnt   = 0;
            first = -1;
            for (int i = 0; i < 4; i++) begin
                if (a[i] != 32'h0) begin
                    cnt++;
                    if (first < 0) first = i;
                end
            end
        end while (cnt > 1 && n < MAX_ITER);
        r.iters     = 8'(n);
        r.no_winner = (cnt == 0);
        r.timeout   = (cnt > 1);
        r.winner    = (cnt == 0) ? 2'd0 : 2'(first);
        r.max_value = (cnt == 0) ? 32'h0 : a[first];
        r.done_cyc  = 0;
    endtask

    // ---------------- scoreboard monitor ----------------------------------
    logic       m_done_d = 1'b0;
    logic       m_mult_d = 1'b0;
    logic [1:0] m_sum_h  = 2'b00;
    int         m_mults  = 0;

    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                m_done_d = 1'b0;
                m_mult_d = 1'b0;
                m_sum_h  = 2'b00;
                m_mults  = 0;
            end else begin
                if (m_sum_h[1]) begin
                    if (act_q.size() == 0) check("act_unexpected", 1, 0);
                    else check("act_after_update", pu_x, act_q.pop_front());
                end
                if (load_mult) begin
                    m_mults++;
                    check("strobe_mult_single", {load_sum, m_mult_d}, 2'b00);
                end
                if (load_sum) check("strobe_sum_after_mult", m_mult_d, 1'b1);
                if (done && !m_done_d) begin
                    if (res_q.size() == 0) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        e = res_q.pop_front();
                        check("winner", winner, e.winner);
                        check("max_value", max_value, e.max_value);
                        check("no_winner", no_winner, e.no_winner);
                        check("timeout", timeout, e.timeout);
                        check("iter_count", iter_count, e.iters);
                        check("done_latency_cycle", cyc, e.done_cyc);
                        check("busy_in_done", busy, 1'b0);
                        check("mult_pulses_per_run", m_mults, int'(e.iters));
                    end
                    m_mults = 0;
                end
                m_done_d = done;
                m_mult_d = load_mult;
                m_sum_h  = {m_sum_h[0], load_sum};
            end
        end
    end

    // ---------------- stimulus --------------------------------------------
    function automatic vec_t mk(input logic [31:0] a, b, c, d);
        vec_t v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int   r;
        for (int i = 0; i < 4; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)       v[i] = {1'b1, 8'($urandom_range(120, 128)), 23'($urandom)};
            else if (r == 2) v[i] = 32'h0;
            else             v[i] = {1'b0, 8'($urandom_range(120, 128)), 23'($urandom)};
        end
        return v;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_pu_x"}, pu_x, '0);
        check({tag, "_flags"}, {load_mult, load_sum, busy, done, no_winner, timeout}, 6'b0);
        check({tag, "_winner"}, winner, 2'd0);
        check({tag, "_max_value"}, max_value, 32'h0);
        check({tag, "_iter_count"}, iter_count, 8'd0);
    endtask

    task automatic run_case(input vec_t x, input bit glitch, input bit chk_act3);
        res_t e;
        int   guard;
        @(negedge clock);
        x_in  = x;
        start = 1'b1;
        model_run(x, e);
        // start sampled at the next edge (cyc+1); done visible 1+3n edges later
        e.done_cyc = cyc + 2 + 3 * int'(e.iters);
        res_q.push_back(e);
        @(negedge clock);
        start = 1'b0;
        if (glitch) begin
            guard = 0;
            while (!load_mult && guard < 20) begin @(negedge clock); guard++; end
            start = 1'b1;       // lands in MULT: must be ignored
            @(negedge clock);
            start = 1'b0;
        end
        if (chk_act3) begin
            guard = 0;
            while (!load_sum && guard < 20) begin @(negedge clock); guard++; end
            @(negedge clock);
            @(negedge clock);
            check("first_update_act3", pu_x[3], 32'h3F240000);
        end
        guard = 0;
        while (!done && guard < 300) begin @(negedge clock); guard++; end
        if (!done) begin
            check("done_wait_expired", 0, 1);
            res_q.delete();
            act_q.delete();
        end
    endtask

    task automatic reset_mid_sum(input vec_t x);
        int guard;
        @(negedge clock);
        x_in  = x;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        guard = 0;
        while (!load_sum && guard < 20) begin @(negedge clock); guard++; end
        check("in_sum_before_reset", load_sum, 1'b1);
        reset = 1'b1;
        res_q.delete();
        act_q.delete();
        @(negedge clock);
        check_reset_values("mid_sum_reset");
        #2 reset = 1'b0;
    endtask

    initial begin : driver
        reset  = 1'b1;
        start  = 1'b0;
        x_in   = '0;
        pu_out = '0;
        pu_s   = '0;
        repeat (2) @(negedge clock);
        check_reset_values("por");
        #2 reset = 1'b0;

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check($sformatf("pu_w_%0d_%0d", i, j), pu_w[i][j], (i == j) ? C_W_SELF : C_W_INHIB);

        run_case(mk(32'hBF800000, 32'h0, 32'h40000000, 32'h0), 1'b0, 1'b0);
        run_case(mk(32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3F400000), 1'b0, 1'b1);
        run_case(mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000), 1'b0, 1'b0);
        run_case(mk(32'hBF800000, 32'h80000000, 32'h0, 32'hC0000000), 1'b0, 1'b0);
        run_case(mk(32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3F400000), 1'b1, 1'b0);
        reset_mid_sum(mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000));
        run_case(mk(32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3F400000), 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            run_case(rand_vec(), ($urandom_range(0, 3) == 0), 1'b0);
        end

        repeat (4) @(negedge clock);
        check("scoreboard_drained", res_q.size() + act_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/maxnet_sequencer.md
# maxnet_sequencer

Iteration controller and activation buffer for the 4-neuron MaxNet built around the floating-point ProcessUnit array. It captures an input vector and rectifies it. It broadcasts the activations and fixed weight rows to four ProcessUnits and drives their `load_mult`/`load_sum` strobes. Results are written back each iteration until at most one neuron stays nonzero, then it reports the winner. It sits directly upstream of the ProcessUnits and consumes their `out`/`s` results.

## Interface

Parameters:
- `MAX_ITER`, default 255: iteration cap before forced termination.
- `W_SELF`, default `32'h3F800000` (+1.0): diagonal weight.
- `W_INHIB`, default `32'hBE000000` (−0.125): off-diagonal weight (−ε).

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a run; sampled in IDLE or DONE only.
- `x_in[3:0]` in 4×32: IEEE-754 single input vector; sampled in LOAD.
- `pu_out[3:0]` in 4×32: `out` of ProcessUnit i.
- `pu_s[3:0]` in 4×1: `s` of ProcessUnit i.
- `pu_x[3:0]` out 4×32: activation vector, broadcast to every ProcessUnit.
- `pu_w[3:0][3:0]` out 4×4×32: weight row i to ProcessUnit i; `W_SELF` at j==i, `W_INHIB` elsewhere; constant.
- `load_mult` out 1: strobe to all ProcessUnits.
- `load_sum` out 1: strobe to all ProcessUnits.
- `busy` out 1: high in LOAD, MULT, SUM and UPDATE.
- `done` out 1: level, high while in DONE.
- `winner` out 2: index of the surviving neuron.
- `max_value` out 32: activation of `winner`.
- `no_winner` out 1: all activations reached zero.
- `timeout` out 1: `MAX_ITER` reached with more than one survivor.
- `iter_count` out 8: iterations completed in this run.

## Operation

States, with transitions:
- IDLE: goes to LOAD on `start`.
- LOAD: goes to MULT.
- MULT: goes to SUM.
- SUM: goes to UPDATE.
- UPDATE: goes to DONE or MULT.
- DONE: goes to LOAD on `start`.

Per-state behaviour:
- LOAD:
  - `act[i] <= x_in[i][31] ? 0 : x_in[i]` (ReLU on entry; −0.0 becomes 0).
  - Clear `iter_count`, `winner`, `max_value`, `no_winner` and `timeout`.
- MULT: `load_mult`=1 for exactly this cycle.
- SUM: `load_sum`=1 for exactly this cycle. Never assert both strobes together.
- UPDATE:
  - `act[i] <= pu_out[i]` and `iter_count++`.
  - Let `cnt` = popcount(`pu_s`).
  - `cnt`==1: go to DONE. Set `winner` = index of the set bit and `max_value` = that `pu_out`.
  - `cnt`==0: go to DONE with `no_winner`=1, `winner`=0 and `max_value`=0.
  - `cnt`>1 and `iter_count+1`==`MAX_ITER`: go to DONE with `timeout`=1. Set `winner` = lowest index with `pu_s` set, and `max_value` = its `pu_out`.
  - Otherwise: go back to MULT.
- At least one iteration always runs, even if only one input is positive.
- `start` while busy is ignored.
- Result outputs hold in DONE until the next LOAD or `reset`.
- `pu_x` = `act` at all times.

## Timing

- Reset values:
  - State is IDLE.
  - `act`, `pu_x`, `winner`, `max_value` and `iter_count` are 0.
  - `load_mult`, `load_sum`, `busy`, `done`, `no_winner` and `timeout` are 0.
- `reset` in any state, including mid-iteration, forces IDLE on that edge. Any partially latched ProcessUnit registers are don't-care; the next LOAD re-initialises.
- Cycle timeline after `start` is sampled at edge E0:
  - LOAD in cycle E0–E1.
  - MULT in cycle E1–E2.
  - SUM in cycle E2–E3.
  - UPDATE in cycle E3–E4.
- One iteration costs 3 cycles.
- `done` rises after edge 1+3·n for n iterations; minimum is 4 edges after `start`.
- `pu_out`/`pu_s` are sampled in UPDATE. They are valid one edge after the `load_sum` cycle.
- Strobes are registered outputs, decoded from state.

## Structure

- Package `maxnet_pkg`:
  - `N`=4.
  - `FP_ONE`, `FP_NEG_EPS` and `FP_ZERO` constants.
  - `state_t` enum {IDLE, LOAD, MULT, SUM, UPDATE, DONE}.
- Sub-module `survivor_encoder`: combinational. Input `pu_s[3:0]`; outputs `cnt[2:0]` and `first_idx[1:0]` (lowest set bit).
- The top instantiates `survivor_encoder`, the FSM and the `act` register file.

## Test plan

- Single positive input: `x_in`={0xBF800000, 0, 0x40000000, 0}.
  - Requires `done` after edge E4, `iter_count`=1, `winner`=2, `max_value`=0x40000000, `no_winner`=0.
- Distinct inputs: `x_in`={0x3F000000, 0x3E800000, 0x3E000000, 0x3F400000}.
  - Requires `winner`=3, `no_winner`=0, `timeout`=0.
  - First UPDATE writes `act[3]`=0x3F240000 (0.640625).
- All ones (tie) with `MAX_ITER`=8: `x_in` = four copies of 0x3F800000.
  - Requires `timeout`=1, `iter_count`=8, `winner`=0.
- All zero or negative inputs.
  - Requires `no_winner`=1, `iter_count`=1, `max_value`=0.
- Control corner cases:
  - Assert `reset` during SUM: next cycle in IDLE with all outputs at reset values.
  - `start` during MULT is ignored.
  - `start` in DONE restarts, with `iter_count` cleared.
- Strobe check over every run: `load_mult` and `load_sum` are never high together, each is high for exactly one cycle per iteration, and MULT always precedes SUM.
